// File: rtl/hidden_layer.sv
// Two-layer fixed-point neural datapath: 10 inputs -> 5 hidden -> 3 outputs.
// Weights live in a 65-entry register file that reloads as a shift chain.
module hidden_layer #(
  parameter int W     = 10,
  parameter int SHIFT = 2
) (
  input  logic         Clock,
  input  logic         Rst,
  input  logic         WE,
  input  logic         In,
  input  logic [W-1:0] inVal   [0:9],
  output logic [W-1:0] outVal  [0:4],
  output logic [W-1:0] outVal1 [0:2],
  output logic [W-1:0] weight  [0:64]
);

  // 10 products of two W-bit words need 2W+4 bits; keep some headroom
  localparam int AW = 2*W + 8;

  logic [AW-1:0] hsum [0:4];
  logic [AW-1:0] osum [0:2];

  function automatic logic [W-1:0] sat(input logic [AW-1:0] s);
    logic [AW-1:0] r;
    r = s >> SHIFT;
    return (|r[AW-1:W]) ? '1 : r[W-1:0];
  endfunction

  always_comb begin
    for (int j = 0; j < 5; j++) begin
      hsum[j] = '0;
      for (int i = 0; i < 10; i++) begin
        hsum[j] = hsum[j]
          + AW'(inVal[i]) * AW'(weight[10*j+i]);
      end
    end
  end

  // output layer works on the registered hidden values
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      osum[k] = '0;
      for (int j = 0; j < 5; j++) begin
        osum[k] = osum[k]
          + AW'(outVal[j]) * AW'(weight[50+5*k+j]);
      end
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      for (int n = 0; n < 65; n++) begin
        weight[n] <= W'((n % 8) + 1);
      end
    end else if (WE) begin
      weight[0] <= inVal[0];
      for (int n = 1; n < 65; n++) begin
        weight[n] <= weight[n-1];
      end
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      for (int j = 0; j < 5; j++) outVal[j] <= '0;
      for (int k = 0; k < 3; k++) outVal1[k] <= '0;
    end else if (In) begin
      for (int j = 0; j < 5; j++) outVal[j] <= sat(hsum[j]);
      for (int k = 0; k < 3; k++) outVal1[k] <= sat(osum[k]);
    end
  end

endmodule

// File: tb/tb_hidden_layer.sv
// Directed bench for hidden_layer: vector table plus
// hand-written reset, hold, shift-load and overlap sequences.
module tb_hidden_layer;

  logic       Clock;
  logic       Rst;
  logic       WE;
  logic       In;
  logic [9:0] inVal   [0:9];
  logic [9:0] outVal  [0:4];
  logic [9:0] outVal1 [0:2];
  logic [9:0] weight  [0:64];

  int total;
  int bad;

  typedef struct {
    int v;
    int hid [5];
    int out [3];
  } vec_t;

  vec_t tbl [6];

  hidden_layer #(.W(10), .SHIFT(2)) dut (
    .Clock  (Clock),
    .Rst    (Rst),
    .WE     (WE),
    .In     (In),
    .inVal  (inVal),
    .outVal (outVal),
    .outVal1(outVal1),
    .weight (weight)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_hid(input string tag, input int h [5]);
    for (int j = 0; j < 5; j++)
      chk($sformatf("%s.outVal[%0d]", tag, j), int'(outVal[j]), h[j]);
  endtask

  task automatic chk_out(input string tag, input int o [3]);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s.outVal1[%0d]", tag, k), int'(outVal1[k]), o[k]);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 10; i++) inVal[i] = 10'(v);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  int h1 [5];
  int o1 [3];
  int z5 [5];
  int z3 [3];

  initial begin
    total = 0;
    bad   = 0;
    h1 = '{9, 10, 11, 12, 9};
    o1 = '{64, 44, 71};
    z5 = '{0, 0, 0, 0, 0};
    z3 = '{0, 0, 0};
    tbl[0] = '{1,    '{9, 10, 11, 12, 9},            '{64, 44, 71}};
    tbl[1] = '{2,    '{19, 21, 23, 25, 19},          '{134, 92, 150}};
    tbl[2] = '{1023, '{1023, 1023, 1023, 1023, 1023}, '{1023, 1023, 1023}};
    tbl[3] = '{0,    '{0, 0, 0, 0, 0},               '{0, 0, 0}};
    tbl[4] = '{4,    '{39, 43, 47, 51, 39},          '{275, 189, 307}};
    tbl[5] = '{1,    '{9, 10, 11, 12, 9},            '{64, 44, 71}};

    Rst = 1'b1;
    WE  = 1'b0;
    In  = 1'b0;
    set_all(0);
    step();
    step();

    chk_hid("reset", z5);
    chk_out("reset", z3);
    for (int n = 0; n < 65; n++)
      chk($sformatf("reset.weight[%0d]", n), int'(weight[n]), (n % 8) + 1);

    @(negedge Clock);
    Rst = 1'b0;

    // WE and In together: compute on old table, shift afterwards
    set_all(1);
    WE = 1'b1;
    In = 1'b1;
    step();
    WE = 1'b0;
    In = 1'b0;
    chk_hid("we_in", h1);
    chk("we_in.weight[0]", int'(weight[0]), 1);
    chk("we_in.weight[1]", int'(weight[1]), 1);
    chk("we_in.weight[2]", int'(weight[2]), 2);
    chk("we_in.weight[3]", int'(weight[3]), 3);
    chk("we_in.weight[9]", int'(weight[9]), 1);

    Rst = 1'b1;
    #1;
    chk("rst2.weight[3]", int'(weight[3]), 4);
    chk_hid("rst2", z5);
    #2;
    Rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      set_all(tbl[t].v);
      In = 1'b1;
      step();
      chk_hid($sformatf("vec%0d.e1", t), tbl[t].hid);
      step();
      chk_hid($sformatf("vec%0d.e2", t), tbl[t].hid);
      chk_out($sformatf("vec%0d.e2", t), tbl[t].out);
    end

    // hold with In low while inputs move
    In = 1'b0;
    set_all(7);
    step();
    step();
    step();
    chk_hid("hold", h1);
    chk_out("hold", o1);

    // single shift-load with compute idle
    inVal[0] = 10'd5;
    WE = 1'b1;
    step();
    WE = 1'b0;
    chk("shift.weight[0]", int'(weight[0]), 5);
    chk("shift.weight[1]", int'(weight[1]), 1);
    chk("shift.weight[2]", int'(weight[2]), 2);
    chk("shift.weight[64]", int'(weight[64]), 8);
    chk_hid("shift", h1);
    chk_out("shift", o1);

    // async reset mid-cycle while streaming
    set_all(1);
    In = 1'b1;
    step();
    step();
    #2;
    Rst = 1'b1;
    #1;
    chk_hid("arst", z5);
    chk_out("arst", z3);
    chk("arst.weight[0]", int'(weight[0]), 1);
    chk("arst.weight[1]", int'(weight[1]), 2);
    chk("arst.weight[64]", int'(weight[64]), 1);
    @(negedge Clock);
    Rst = 1'b0;
    step();
    chk_hid("post.e1", h1);
    chk_out("post.e1", z3);
    step();
    chk_hid("post.e2", h1);
    chk_out("post.e2", o1);
    In = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
